// File: rtl/sdio_pkg.sv
// Shared types and constants for the SDIO command-to-UART sniffer path.
// Define SDIO_UART_CKSUM_EN to append an XOR checksum byte to every frame.
package sdio_pkg;

  localparam int REC_W           = 38;
  localparam int FRAME_LEN_PLAIN = 6;
  localparam int FRAME_LEN_CKSUM = 7;

`ifdef SDIO_UART_CKSUM_EN
  localparam int FRAME_LEN = FRAME_LEN_CKSUM;
`else
  localparam int FRAME_LEN = FRAME_LEN_PLAIN;
`endif

  typedef enum logic [1:0] {FRM_IDLE, FRM_LOAD, FRM_SEND, FRM_NEXT} frm_state_t;
  typedef enum logic [1:0] {UTX_IDLE, UTX_START, UTX_DATA, UTX_STOP} utx_state_t;

  // Byte idx of the frame built from a {cmd[5:0], arg[31:0]} record.
  function automatic logic [7:0] frame_byte(input logic [REC_W-1:0] rec,
                                            input logic [2:0] idx,
                                            input logic [7:0] sync);
    logic [7:0] b;
    b = sync;
    case (idx)
      3'd1: b = {2'b00, rec[37:32]};
      3'd2: b = rec[31:24];
      3'd3: b = rec[23:16];
      3'd4: b = rec[15:8];
      3'd5: b = rec[7:0];
`ifdef SDIO_UART_CKSUM_EN
      3'd6: b = {2'b00, rec[37:32]} ^ rec[31:24] ^ rec[23:16] ^ rec[15:8] ^ rec[7:0];
`endif
      default: b = sync;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/sdio_uart_framer_if.sv
// Completed-record handoff from the SDIO command sampler to the UART framer.
interface sdio_uart_framer_if;
  logic [7:0]  cmd_i;
  logic [32:0] arg_i;
  logic        finsh_i;

  modport master (output cmd_i, output arg_i, output finsh_i);
  modport slave  (input cmd_i, input arg_i, input finsh_i);
endinterface

// File: rtl/uart_tx_core.sv
// 8N1 LSB-first UART transmitter; each bit lasts BAUD_DIV clocks, done pulses after STOP.
module uart_tx_core
  import sdio_pkg::*;
#(
  parameter int BAUD_DIV = 434
) (
  input  logic       sd_clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       start,
  output logic       tx,
  output logic       done,
  output logic       busy
);

  localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

  utx_state_t    state;
  logic [CW-1:0] cnt;
  logic [2:0]    bitn;
  logic [7:0]    shreg;
  logic          cnt_last;

  assign cnt_last = (cnt == CW'(BAUD_DIV - 1));
  assign busy     = (state != UTX_IDLE);

  always_ff @(posedge sd_clk) begin
    if (state == UTX_IDLE && start) shreg <= data;
  end

  always_ff @(posedge sd_clk or posedge rst) begin
    if (rst) begin
      state <= UTX_IDLE;
      cnt   <= '0;
      bitn  <= '0;
      tx    <= 1'b1;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        UTX_IDLE: begin
          if (start) begin
            state <= UTX_START;
            cnt   <= '0;
            tx    <= 1'b0;
          end
        end
        UTX_START: begin
          if (cnt_last) begin
            cnt   <= '0;
            bitn  <= '0;
            tx    <= shreg[0];
            state <= UTX_DATA;
          end else cnt <= cnt + CW'(1);
        end
        UTX_DATA: begin
          if (cnt_last) begin
            cnt <= '0;
            if (bitn == 3'd7) begin
              tx    <= 1'b1;
              state <= UTX_STOP;
            end else begin
              bitn <= bitn + 3'd1;
              tx   <= shreg[bitn + 3'd1];
            end
          end else cnt <= cnt + CW'(1);
        end
        UTX_STOP: begin
          if (cnt_last) begin
            cnt   <= '0;
            done  <= 1'b1;
            state <= UTX_IDLE;
          end else cnt <= cnt + CW'(1);
        end
        default: state <= UTX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/sdio_uart_framer.sv
// Queues SDIO command records and serialises each as a byte frame on an 8N1 UART line.
// Build option: SDIO_UART_CKSUM_EN adds a trailing XOR checksum byte (7-byte frames).
module sdio_uart_framer
  import sdio_pkg::*;
#(
  parameter int         FIFO_DEPTH = 8,
  parameter int         BAUD_DIV   = 434,
  parameter logic [7:0] SYNC_BYTE  = 8'hA5
) (
  input  logic                          sd_clk,
  input  logic                          rst,
  sdio_uart_framer_if.slave             rec,
  output logic                          uart_tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [7:0]                    drop_cnt
);

  localparam int         AW          = $clog2(FIFO_DEPTH);
  localparam int         LVL_W       = AW + 1;
  localparam logic [2:0] FRAME_LEN_B = 3'(FRAME_LEN);

  logic             finsh_p0;
  logic             push, push_ok, pop, full, empty;
  logic [AW-1:0]    wptr, rptr;
  logic [REC_W-1:0] mem [FIFO_DEPTH];
  logic [REC_W-1:0] hold_rec;
  frm_state_t       fstate;
  logic [2:0]       byte_idx;
  logic             tx_start;
  logic [7:0]       tx_data;
  logic             tx_done, core_busy;
  logic             unused_bits;

  assign unused_bits = ^{rec.cmd_i[7:6], rec.arg_i[32]};

  assign push    = rec.finsh_i & ~finsh_p0;
  assign empty   = (fifo_level == '0);
  assign full    = (fifo_level == LVL_W'(FIFO_DEPTH));
  assign pop     = (fstate == FRM_IDLE) & ~empty;
  // A push into a full FIFO still lands when a pop frees the slot this cycle.
  assign push_ok = push & (~full | pop);
  assign busy    = (fstate != FRM_IDLE) | core_busy | ~empty;

  always_ff @(posedge sd_clk or posedge rst) begin
    if (rst) begin
      finsh_p0   <= 1'b0;
      wptr       <= '0;
      rptr       <= '0;
      fifo_level <= '0;
      drop_cnt   <= '0;
    end else begin
      finsh_p0 <= rec.finsh_i;
      if (push_ok) wptr <= wptr + AW'(1);
      if (pop)     rptr <= rptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   fifo_level <= fifo_level + LVL_W'(1);
        2'b01:   fifo_level <= fifo_level - LVL_W'(1);
        default: fifo_level <= fifo_level;
      endcase
      if (push && !push_ok && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end

  always_ff @(posedge sd_clk) begin
    if (push_ok) mem[wptr] <= {rec.cmd_i[5:0], rec.arg_i[31:0]};
    if (pop)     hold_rec  <= mem[rptr];
  end

  // Next byte is staged while SEND sees done, so the core restarts from NEXT.
  always_ff @(posedge sd_clk) begin
    if (pop) tx_data <= SYNC_BYTE;
    else if (fstate == FRM_SEND && tx_done)
      tx_data <= frame_byte(hold_rec, byte_idx + 3'd1, SYNC_BYTE);
  end

  always_ff @(posedge sd_clk or posedge rst) begin
    if (rst) begin
      fstate   <= FRM_IDLE;
      byte_idx <= '0;
      tx_start <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      case (fstate)
        FRM_IDLE: begin
          if (!empty) begin
            fstate   <= FRM_LOAD;
            tx_start <= 1'b1;
          end
        end
        FRM_LOAD: begin
          byte_idx <= '0;
          fstate   <= FRM_SEND;
        end
        FRM_SEND: begin
          if (tx_done) begin
            fstate   <= FRM_NEXT;
            tx_start <= (byte_idx + 3'd1 != FRAME_LEN_B);
          end
        end
        FRM_NEXT: begin
          byte_idx <= byte_idx + 3'd1;
          fstate   <= (byte_idx + 3'd1 == FRAME_LEN_B) ? FRM_IDLE : FRM_SEND;
        end
        default: fstate <= FRM_IDLE;
      endcase
    end
  end

  uart_tx_core #(.BAUD_DIV(BAUD_DIV)) u_tx (
    .sd_clk (sd_clk),
    .rst    (rst),
    .data   (tx_data),
    .start  (tx_start),
    .tx     (uart_tx),
    .done   (tx_done),
    .busy   (core_busy)
  );

endmodule

// File: tb/tb_sdio_uart_framer.sv
// Bench for sdio_uart_framer: cycle-level waveform model plus literal frame checks.
module tb_sdio_uart_framer;
  localparam int B     = 4;
  localparam int DEPTH = 4;
  localparam logic [7:0] SYNC = 8'hA5;
`ifdef SDIO_UART_CKSUM_EN
  localparam int L = 7;
`else
  localparam int L = 6;
`endif
  localparam int BYTE_T = 10 * B + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic uart_tx, busy;
  logic [$clog2(DEPTH):0] fifo_level;
  logic [7:0] drop_cnt;
  int cyc = 0;
  int total = 0;
  int bad = 0;

  sdio_uart_framer_if rec_if ();

  sdio_uart_framer #(.FIFO_DEPTH(DEPTH), .BAUD_DIV(B), .SYNC_BYTE(SYNC)) dut (
    .sd_clk     (clk),
    .rst        (rst),
    .rec        (rec_if),
    .uart_tx    (uart_tx),
    .busy       (busy),
    .fifo_level (fifo_level),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic logic [7:0] exp_byte(input logic [37:0] r, input int k);
    logic [7:0] cb;
    cb = {2'b00, r[37:32]};
    if (k == 0) return SYNC;
    if (k == 1) return cb;
    if (k <= 5) return 8'((r[31:0] >> (8 * (5 - k))) & 32'hFF);
    return cb ^ r[31:24] ^ r[23:16] ^ r[15:8] ^ r[7:0];
  endfunction

  // Reference model state
  logic [37:0] m_q[$];
  logic [37:0] m_cur;
  logic        m_active = 1'b0;
  logic        m_prev = 1'b0;
  int          m_p = 0;
  int          m_free = 0;
  int          m_drop = 0;
  logic [7:0]  rx_q[$];

  initial begin
    logic etx;
    logic [7:0] eb;
    int off, k, j, bn;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_q.delete();
        m_active = 1'b0;
        m_drop = 0;
        m_prev = 1'b0;
      end else if (m_active && cyc >= m_free) m_active = 1'b0;
      etx = 1'b1;
      if (m_active && cyc >= m_p + 2) begin
        off = cyc - (m_p + 2);
        k = off / BYTE_T;
        j = off % BYTE_T;
        if (k < L && j < 10 * B) begin
          bn = j / B;
          eb = exp_byte(m_cur, k);
          if (bn == 0) etx = 1'b0;
          else if (bn == 9) etx = 1'b1;
          else etx = eb[bn-1];
        end
      end
      check("uart_tx", 64'(uart_tx), 64'(etx));
      check("busy", 64'(busy), 64'(m_active || m_q.size() != 0));
      check("fifo_level", 64'(fifo_level), 64'(m_q.size()));
      check("drop_cnt", 64'(drop_cnt), 64'(m_drop));
      if (!rst) begin
        logic rise;
        rise = rec_if.finsh_i && !m_prev;
        m_prev = rec_if.finsh_i;
        if (!m_active && m_q.size() != 0) begin
          m_cur = m_q.pop_front();
          m_active = 1'b1;
          m_p = cyc;
          m_free = cyc + L * BYTE_T + 2;
        end
        if (rise) begin
          if (m_q.size() < DEPTH) m_q.push_back({rec_if.cmd_i[5:0], rec_if.arg_i[31:0]});
          else if (m_drop < 255) m_drop++;
        end
      end
    end
  end

  // Independent mid-bit UART receiver
  initial begin
    logic prev;
    logic [7:0] b;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst && prev && !uart_tx) begin
        repeat (B / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (B) @(negedge clk);
          b[i] = uart_tx;
        end
        repeat (B) @(negedge clk);
        rx_q.push_back(b);
      end
      prev = uart_tx;
    end
  end

  task automatic pulse(input logic [5:0] c, input logic [31:0] a, input int hold);
    @(posedge clk); #1;
    rec_if.cmd_i = {2'($urandom_range(0, 3)), c};
    rec_if.arg_i = {1'($urandom_range(0, 1)), a};
    rec_if.finsh_i = 1'b1;
    repeat (hold) begin @(posedge clk); #1; end
    rec_if.finsh_i = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc);
    int n;
    n = 0;
    while ((m_active || m_q.size() != 0) && n < max_cyc) begin
      @(posedge clk); #1;
      n++;
    end
    check("idle_timeout", 64'(n >= max_cyc), 64'(0));
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic check_rx(input string name, input logic [7:0] exp [7]);
    check({name, "_count"}, 64'(rx_q.size()), 64'(L));
    for (int i = 0; i < L && i < rx_q.size(); i++)
      check(name, 64'(rx_q[i]), 64'(exp[i]));
  endtask

  initial begin
    logic [7:0] lit_a [7];
    logic [7:0] lit_b [7];
    int peak, n;
    lit_a = '{8'hA5, 8'h03, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h21};
    lit_b = '{8'hA5, 8'h11, 8'h00, 8'h00, 8'h10, 8'h00, 8'h01};
    rec_if.cmd_i = '0;
    rec_if.arg_i = '0;
    rec_if.finsh_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_uart_tx", 64'(uart_tx), 64'(1));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_level", 64'(fifo_level), 64'(0));
    check("rst_drop", 64'(drop_cnt), 64'(0));
    rst = 1'b0;
    repeat (3) @(posedge clk);

    // Basic frames
    rx_q.delete();
    pulse(6'h03, 32'hDEADBEEF, 1);
    check("level_after_push", 64'(fifo_level), 64'(1));
    wait_idle(2000);
    check_rx("frame_a", lit_a);
    check("busy_after_frame", 64'(busy), 64'(0));
    rx_q.delete();
    pulse(6'h11, 32'h00001000, 1);
    wait_idle(2000);
    check_rx("frame_b", lit_b);

    // Level held high
    rx_q.delete();
    peak = 0;
    @(posedge clk); #1;
    rec_if.cmd_i = 8'h05;
    rec_if.arg_i = 33'h012345678;
    rec_if.finsh_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (int'(fifo_level) > peak) peak = int'(fifo_level);
    end
    rec_if.finsh_i = 1'b0;
    wait_idle(2000);
    check("hold_peak", 64'(peak), 64'(1));
    check("hold_bytes", 64'(rx_q.size()), 64'(L));

    // Overflow then simultaneous push/pop while full
    rx_q.delete();
    for (int i = 0; i < 7; i++) pulse(6'(i + 1), 32'h100 + 32'(i), 1);
    check("ovf_level", 64'(fifo_level), 64'(4));
    check("ovf_drop", 64'(drop_cnt), 64'(2));
    n = 0;
    do begin @(posedge clk); #1; n++; end while (cyc != m_free && n < 2000);
    check("pushpop_timeout", 64'(n >= 2000), 64'(0));
    rec_if.cmd_i = 8'h2A;
    rec_if.arg_i = 33'h0CAFEF00D;
    rec_if.finsh_i = 1'b1;
    @(posedge clk); #1;
    rec_if.finsh_i = 1'b0;
    check("pushpop_level", 64'(fifo_level), 64'(4));
    check("pushpop_drop", 64'(drop_cnt), 64'(2));
    wait_idle(4000);
    check("ovf_bytes", 64'(rx_q.size()), 64'(6 * L));

    // Saturating drop counter, then reset mid-frame
    for (int i = 0; i < 300; i++) pulse(6'($urandom), $urandom, 1);
    check("drop_sat", 64'(drop_cnt), 64'(255));
    n = 0;
    do begin @(posedge clk); #1; n++; end
      while (cyc != m_p + 2 + 3 * BYTE_T + 2 * B && n < 2000);
    check("mid_timeout", 64'(n >= 2000), 64'(0));
    rst = 1'b1;
    #1;
    check("mid_rst_tx", 64'(uart_tx), 64'(1));
    check("mid_rst_level", 64'(fifo_level), 64'(0));
    check("mid_rst_drop", 64'(drop_cnt), 64'(0));
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (60) @(posedge clk);
    rx_q.delete();
    pulse(6'h11, 32'h00001000, 1);
    wait_idle(2000);
    check_rx("frame_after_rst", lit_b);

    // Randomised traffic
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(1, 200)) @(posedge clk);
      pulse(6'($urandom), $urandom, $urandom_range(1, 3));
    end
    wait_idle(15000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
